alu_wb_stage: RTL and testbench
===============================

ALU_WB_STAGE -- requirements
Module: alu_wb_stage

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; ports named clk and reset.
REQ-002 SHALL have port: clk  in  1  rising-edge clock.
REQ-003 SHALL have port: reset  in  1  async active-high reset.
REQ-004 SHALL have port: start  in  1  request to execute one instruction; sampled only while busy=0.
REQ-005 SHALL have port: op  in  3  operation: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT (signed), 101 MUL, 110 SLL, 111 reserved.
REQ-006 SHALL have port: rs  in  5  source register 1 index.
REQ-007 SHALL have port: rt  in  5  source register 2 index.
REQ-008 SHALL have port: rd  in  5  destination register index.
REQ-009 SHALL have port: ra1  out  5  regfile read address 1.
REQ-010 SHALL have port: ra2  out  5  regfile read address 2.
REQ-011 SHALL have port: rd1  in  32  regfile read data 1, combinational from ra1.
REQ-012 SHALL have port: rd2  in  32  regfile read data 2, combinational from ra2.
REQ-013 SHALL have port: we3  out  1  regfile write enable.
REQ-014 SHALL have port: wa3  out  5  regfile write address.
REQ-015 SHALL have port: wd3  out  32  regfile write data.
REQ-016 SHALL have port: busy  out  1  high in every state except IDLE.
REQ-017 SHALL have port: done  out  1  one-cycle pulse in WB state.

Function
REQ-018 SHALL implement a registered FSM: IDLE, READ, EXEC, MUL, WB.
REQ-019 IDLE: start=1 at a rising edge SHALL latch op, rs, rt, rd into internal registers; next state READ.
REQ-020 start while busy=1 SHALL be ignored; no queuing, no latch update.
REQ-021 READ: ra1/ra2 SHALL drive latched rs/rt; at end of cycle rd1/rd2 captured into A/B; next MUL if op=101, else EXEC.
REQ-022 ra1/ra2 SHALL be 0 in all states other than READ.
REQ-023 EXEC: result register SHALL load ADD A+B, SUB A-B, AND A&B, OR A|B, SLT {31'b0, signed(A)<signed(B)}, SLL A<<B[4:0], reserved 0; all mod 2^32; next WB.
REQ-024 MUL: iterative shift-add, one multiplier bit per cycle, exactly 32 cycles via 5-bit counter; result = low 32 bits of A*B; next WB after the 32nd cycle.
REQ-025 WB: done=1 for exactly one cycle; wa3=latched rd, wd3=result; next IDLE.
REQ-026 WB: we3=1 only if rd!=0 and op!=111; otherwise we3=0 with done still 1.
REQ-027 we3, wa3, wd3, done SHALL be 0 in every state other than WB.
REQ-028 Latency from accepting edge: ALU ops WB in 3rd following cycle; MUL WB in 34th following cycle.
REQ-029 Earliest next accept SHALL be the first IDLE cycle after WB (no back-to-back overlap); regfile write in WB therefore precedes next READ.

Reset
REQ-030 reset=1 SHALL immediately (asynchronously) force state IDLE, counter 0, A, B, result and latched fields 0.
REQ-031 During and after reset all outputs SHALL be 0 (busy=0, done=0, we3=0, ra1=ra2=0, wa3=0, wd3=0).
REQ-032 reset asserted mid-operation SHALL abort it with no writeback; start is not accepted while reset=1.

Verification
REQ-033 Reset: assert reset mid-cycle -> all outputs 0 without waiting for clk edge.
REQ-034 ADD: start op=000 rs=1 rt=2 rd=3, model rd1=12 rd2=5 -> ra1=1 ra2=2 in READ; 3rd cycle after accept we3=1 wa3=3 wd3=17 done=1.
REQ-035 SUB/SLT: rd1=5 rd2=12 SUB -> wd3=32'hFFFFFFF9; rd1=32'hFFFFFFFF rd2=1 SLT -> wd3=1; SLL rd1=1 rd2=32'h24 -> wd3=16.
REQ-036 MUL: rd1=7 rd2=6 -> busy=1 for 34 cycles, wd3=42 on 34th cycle; rd1=rd2=32'h10000 -> wd3=0.
REQ-037 rd=0 or op=111 -> done=1 in WB, we3 stays 0; start pulsed during busy -> ignored, single WB only.
REQ-038 reset pulsed in 10th MUL cycle -> busy=0 immediately, we3 never asserted; next start executes normally.

Source files
------------

// File: rtl/alu_wb_stage.sv
// alu_wb_stage
//   Multi-cycle execute/writeback stage. Accepts one instruction while idle,
//   reads both operands from an external register file, computes the result
//   (single-cycle ALU or 32-cycle iterative multiply) and issues one writeback.
//
// Ports
//   clk, reset        : rising-edge clock, asynchronous active-high reset
//   start             : accept request (ignored while busy)
//   op, rs, rt, rd    : operation code and register indices
//   ra1, ra2          : regfile read addresses (non-zero only in READ)
//   rd1, rd2          : regfile read data, combinational from ra1/ra2
//   we3, wa3, wd3     : regfile write port (active only in WB)
//   busy, done        : busy outside IDLE, done pulses in WB
module alu_wb_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    output logic [4:0]  ra1,
    output logic [4:0]  ra2,
    input  logic [31:0] rd1,
    input  logic [31:0] rd2,
    output logic        we3,
    output logic [4:0]  wa3,
    output logic [31:0] wd3,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_EXEC, S_MUL, S_WB
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_RSV = 3'b111;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [4:0]  rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [31:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [4:0]  cnt_q, cnt_d;

    logic        busy_q, busy_d, done_q, done_d, we3_q, we3_d;
    logic [4:0]  ra1_q, ra1_d, ra2_q, ra2_d, wa3_q, wa3_d;
    logic [31:0] wd3_q, wd3_d;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    rs_d    = rs;
                    rt_d    = rt;
                    rd_d    = rd;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                a_d     = rd1;
                b_d     = rd2;
                res_d   = 32'd0;
                cnt_d   = 5'd0;
                state_d = (op_q == OP_MUL) ? S_MUL : S_EXEC;
            end
            S_EXEC: begin
                case (op_q)
                    OP_ADD:  res_d = a_q + b_q;
                    OP_SUB:  res_d = a_q - b_q;
                    OP_AND:  res_d = a_q & b_q;
                    OP_OR:   res_d = a_q | b_q;
                    OP_SLT:  res_d = {31'd0, $signed(a_q) < $signed(b_q)};
                    OP_SLL:  res_d = a_q << b_q[4:0];
                    default: res_d = 32'd0;
                endcase
                state_d = S_WB;
            end
            S_MUL: begin
                // Shift-add: A walks left, B walks right, LSB of B gates the add.
                if (b_q[0]) res_d = res_q + a_q;
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = S_WB;
            end
            S_WB: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered, so they are decoded from the next state.
        busy_d = (state_d != S_IDLE);
        ra1_d  = (state_d == S_READ) ? rs_d : 5'd0;
        ra2_d  = (state_d == S_READ) ? rt_d : 5'd0;
        done_d = (state_d == S_WB);
        we3_d  = (state_d == S_WB) && (rd_d != 5'd0) && (op_d != OP_RSV);
        wa3_d  = (state_d == S_WB) ? rd_d  : 5'd0;
        wd3_d  = (state_d == S_WB) ? res_d : 32'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= 3'd0;
            rs_q    <= 5'd0;
            rt_q    <= 5'd0;
            rd_q    <= 5'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            res_q   <= 32'd0;
            cnt_q   <= 5'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we3_q   <= 1'b0;
            ra1_q   <= 5'd0;
            ra2_q   <= 5'd0;
            wa3_q   <= 5'd0;
            wd3_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            we3_q   <= we3_d;
            ra1_q   <= ra1_d;
            ra2_q   <= ra2_d;
            wa3_q   <= wa3_d;
            wd3_q   <= wd3_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign we3  = we3_q;
    assign ra1  = ra1_q;
    assign ra2  = ra2_q;
    assign wa3  = wa3_q;
    assign wd3  = wd3_q;

endmodule

// File: tb/tb_alu_wb_stage.sv
// Scoreboard bench for alu_wb_stage: the driver pushes the expected writeback
// when an instruction is accepted, a negedge monitor checks every cycle.
module tb_alu_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [4:0]  ra1, ra2;
    logic [31:0] rd1, rd2;
    logic        we3;
    logic [4:0]  wa3;
    logic [31:0] wd3;
    logic        busy, done;

    logic [31:0] rf [32];
    assign rd1 = rf[ra1];
    assign rd2 = rf[ra2];

    alu_wb_stage dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs(rs), .rt(rt), .rd(rd), .ra1(ra1), .ra2(ra2),
        .rd1(rd1), .rd2(rd2), .we3(we3), .wa3(wa3), .wd3(wd3),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          acc;
        int          lat;
        logic [4:0]  rs, rt, rd;
        logic        we;
        logic [31:0] wd;
    } exp_t;
    exp_t q[$];

    int n_vec = 0;
    int n_bad = 0;
    bit run = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    // Reference: plain arithmetic on the operand values.
    function automatic logic [31:0] ref_alu(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint unsigned p;
        case (o)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd5: begin p = longint'(a) * longint'(b); return p[31:0]; end
            3'd6: return a << (b % 32);
            default: return 32'd0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (run && !reset) begin
            chk("busy", {31'd0, busy}, {31'd0, q.size() != 0});
            if (q.size() != 0) begin
                if (cyc == q[0].acc) begin
                    chk("ra1", {27'd0, ra1}, {27'd0, q[0].rs});
                    chk("ra2", {27'd0, ra2}, {27'd0, q[0].rt});
                end else begin
                    chk("ra_idle", {22'd0, ra1, ra2}, 32'd0);
                end
                if (cyc == q[0].acc + q[0].lat) begin
                    chk("done", {31'd0, done}, 32'd1);
                    chk("we3",  {31'd0, we3},  {31'd0, q[0].we});
                    chk("wa3",  {27'd0, wa3},  {27'd0, q[0].rd});
                    chk("wd3",  wd3, q[0].wd);
                    void'(q.pop_front());
                end else begin
                    chk("wb_quiet", {25'd0, done, we3, wa3} | wd3, 32'd0);
                end
            end else begin
                chk("idle_quiet", {25'd0, done, we3, wa3} | wd3 | {22'd0, ra1, ra2}, 32'd0);
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic [4:0] s, input logic [4:0] t,
                         input logic [4:0] d, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        @(negedge clk);
        rf[s] = a;
        rf[t] = b;
        op = o; rs = s; rt = t; rd = d; start = 1'b1;
        e.rs  = s;
        e.rt  = t;
        e.rd  = d;
        e.lat = (o == 3'd5) ? 33 : 2;
        e.we  = (d != 5'd0) && (o != 3'd7);
        e.wd  = ref_alu(o, rf[s], rf[t]);
        @(posedge clk);
        #1;
        e.acc = cyc;
        q.push_back(e);
        start = 1'b0;
    endtask

    // Wait for the outstanding instruction; optionally toggle start and junk
    // fields while busy, which must all be ignored.
    task automatic wait_idle(input bit junk);
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            #2;
            n++;
            if (junk && q.size() != 0) begin
                start = 1'($urandom_range(0, 1));
                op = 3'($urandom); rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
            end
        end
        start = 1'b0;
        if (q.size() != 0) begin
            chk("timeout", 32'd1, 32'd0);
            q.delete();
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {20'd0, busy, done, we3, ra1, ra2} | {27'd0, wa3} | wd3, 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'd0; rs = 5'd0; rt = 5'd0; rd = 5'd0;
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        #3;
        chk_all_zero("reset_outputs");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        run = 1'b1;

        issue(3'd0, 5'd1, 5'd2, 5'd3, 32'd12, 32'd5);               wait_idle(0);
        issue(3'd1, 5'd4, 5'd5, 5'd6, 32'd5, 32'd12);               wait_idle(0);
        issue(3'd4, 5'd7, 5'd8, 5'd9, 32'hFFFFFFFF, 32'd1);         wait_idle(0);
        issue(3'd6, 5'd10, 5'd11, 5'd12, 32'd1, 32'h24);            wait_idle(0);
        issue(3'd5, 5'd13, 5'd14, 5'd15, 32'd7, 32'd6);             wait_idle(0);
        issue(3'd5, 5'd16, 5'd17, 5'd18, 32'h10000, 32'h10000);     wait_idle(0);
        issue(3'd0, 5'd1, 5'd2, 5'd0, 32'd3, 32'd4);                wait_idle(1);
        issue(3'd7, 5'd1, 5'd2, 5'd20, 32'd3, 32'd4);               wait_idle(1);

        // Reset in the 10th MUL cycle aborts without writeback.
        issue(3'd5, 5'd21, 5'd22, 5'd23, 32'd99, 32'd77);
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b1;
        q.delete();
        #1;
        chk_all_zero("reset_mid_mul");
        start = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_all_zero("reset_holds");
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        issue(3'd0, 5'd1, 5'd2, 5'd3, 32'd12, 32'd5);               wait_idle(0);

        for (int k = 0; k < 40; k++) begin
            issue(3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom);
            wait_idle(1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        run = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
